muldiv_unit_e: RTL and testbench
================================

# muldiv_unit_e

Iterative RV32M multiply/divide unit in the execute stage, consuming operands and control held in the decode/execute pipeline register. On a valid M-extension op it latches operands, stalls fetch/decode/execute via the hazard unit until the result is ready, then presents a one-cycle result to the execute-stage result mux for writeback through the execute/memory register. Flush from the hazard unit aborts an op in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (only 32 supported)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- MulDivE  in  1  execute-stage instruction is an M-extension op (funct7=0000001, opcode OP)
- funct3E  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  in  DATA_WIDTH  rs1 value after forwarding
- SrcBE  in  DATA_WIDTH  rs2 value after forwarding
- FlushE  in  1  abort current op, return to IDLE
- StallMD  out  1  to hazard unit: hold PC, F/D and D/E registers, bubble E/M
- DoneE  out  1  ResultE valid this cycle
- ResultE  out  DATA_WIDTH  multiply/divide result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if MulDivE=1 and FlushE=0 -> latch funct3E, |SrcAE|, |SrcBE| (as signed/unsigned per op), result sign flags; StallMD=1 combinationally; count=0; -> BUSY (or DONE for early-out cases).
- BUSY: one iteration per cycle, count 0..31; StallMD=1; after count=31 -> DONE.
- Multiply: shift-add on magnitudes into 64-bit accumulator; negate if sign flags differ. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32]. MULHSU: rs1 signed, rs2 unsigned.
- Divide: restoring division on magnitudes, 32-bit quotient and remainder. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Divide by zero (SrcBE=0): early-out IDLE->DONE; quotient 0xFFFFFFFF, remainder = SrcAE (signed and unsigned).
- Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): early-out; quotient 0x80000000, remainder 0.
- DONE: DoneE=1, ResultE valid, StallMD=0 so pipeline advances; MulDivE ignored; -> IDLE next cycle.
- FlushE=1 in any state -> IDLE next cycle, DoneE=0, no result; FlushE has priority over start.
- rst: state IDLE, count 0, ResultE 0, DoneE 0; StallMD forced 0 while rst=1.

## Timing
- Op accepted in cycle T (IDLE, MulDivE=1): StallMD=1 in T combinationally.
- Iterative path: BUSY T+1..T+32, DONE at T+33; StallMD=1 for T..T+32, 0 at T+33; instruction occupies E for 34 cycles.
- Early-out path: DONE at T+1; E occupancy 2 cycles.
- ResultE holds last value outside DONE; consumers must qualify with DoneE.
- Back-to-back M ops: second op seen in IDLE at T+34 earliest; no re-trigger of same instruction since DONE ignores MulDivE.
- rst mid-op: IDLE on next edge, no result issued.

## Configuration
- FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier; IDLE->DONE at T+1, occupancy 2 cycles. Divides unchanged.
- FAST_MUL_EN undefined: multiplies use the 32-iteration shift-add path, same latency as divides.

## Test plan
- MUL 7 x 0xFFFFFFFD (-3) -> DoneE at T+33 (T+1 with FAST_MUL_EN), ResultE 0xFFFFFFEB; StallMD high exactly T..T+32.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start DIVU, assert FlushE at T+10 -> IDLE at T+11, DoneE never asserted, StallMD 0 from T+11.
- Assert rst at T+5 of a DIV -> ResultE 0, DoneE 0, StallMD 0 next cycle; new MUL after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit_e.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes.
// Optional FAST_MUL_EN macro swaps the multiply path for a single-cycle 33x33 signed multiplier.
module muldiv_unit_e #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MulDivE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  FlushE,
  output logic                  StallMD,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] ResultE
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [2:0]  op;
  logic        neg;
  logic [31:0] divisor;
  logic [63:0] acc;

  logic        is_div, a_signed, b_signed, neg_a, neg_b, neg_start;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, early;
  logic [31:0] early_res;

  assign is_div    = funct3E[2];
  assign a_signed  = is_div ? ~funct3E[0] : (funct3E != 3'b011);
  assign b_signed  = is_div ? ~funct3E[0] : ~funct3E[1];
  assign neg_a     = a_signed & SrcAE[31];
  assign neg_b     = b_signed & SrcBE[31];
  assign mag_a     = neg_a ? -SrcAE : SrcAE;
  assign mag_b     = neg_b ? -SrcBE : SrcBE;
  // Remainder takes the dividend's sign; everything else the XOR of both
  assign neg_start = (is_div & funct3E[1]) ? neg_a : (neg_a ^ neg_b);
  assign div_zero  = is_div & (SrcBE == 32'd0);
  assign div_ovf   = is_div & ~funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);

`ifdef FAST_MUL_EN
  logic signed [63:0] fast_prod;
  assign fast_prod = $signed({neg_a, SrcAE}) * $signed({neg_b, SrcBE});
  assign early = div_zero | div_ovf | ~is_div;
  always_comb begin
    early_res = 32'd0;
    if (!is_div)       early_res = (funct3E == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
    else if (div_zero) early_res = funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
    else if (div_ovf)  early_res = funct3E[1] ? 32'd0 : 32'h8000_0000;
  end
`else
  assign early = div_zero | div_ovf;
  always_comb begin
    early_res = 32'd0;
    if (div_zero)     early_res = funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
    else if (div_ovf) early_res = funct3E[1] ? 32'd0 : 32'h8000_0000;
  end
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mul_sum, div_t, div_diff;
  logic [63:0] mul_nxt, div_nxt, acc_nxt, prod;
  logic [31:0] div_val, final_res;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
  assign mul_nxt  = {mul_sum, acc[31:1]};
  assign div_t    = acc[63:31];
  assign div_diff = div_t - {1'b0, divisor};
  assign div_nxt  = div_diff[32] ? {div_t[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};
  assign acc_nxt  = op[2] ? div_nxt : mul_nxt;
  assign prod     = neg ? -acc_nxt : acc_nxt;
  assign div_val  = op[1] ? acc_nxt[63:32] : acc_nxt[31:0];

  always_comb begin
    final_res = 32'd0;
    if (op[2])              final_res = neg ? -div_val : div_val;
    else if (op == 3'b000)  final_res = prod[31:0];
    else                    final_res = prod[63:32];
  end

  assign StallMD = ~rst & ((state == BUSY) | ((state == IDLE) & MulDivE & ~FlushE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 5'd0;
      op      <= 3'd0;
      neg     <= 1'b0;
      divisor <= 32'd0;
      acc     <= 64'd0;
      DoneE   <= 1'b0;
      ResultE <= '0;
    end else if (FlushE) begin
      state <= IDLE;
      count <= 5'd0;
      DoneE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DoneE <= 1'b0;
          if (MulDivE) begin
            op      <= funct3E;
            neg     <= neg_start;
            divisor <= mag_b;
            acc     <= {32'd0, mag_a};
            count   <= 5'd0;
            if (early) begin
              state   <= DONE;
              DoneE   <= 1'b1;
              ResultE <= early_res;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state   <= DONE;
            DoneE   <= 1'b1;
            ResultE <= final_res;
          end
        end
        DONE: begin
          DoneE <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          DoneE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit_e.sv
// Self-checking bench for muldiv_unit_e: directed vector table, random ops against an
// arithmetic reference, plus flush / reset / result-hold sequences.
module tb_muldiv_unit_e;

  logic        clk = 1'b0;
  logic        rst;
  logic        MulDivE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        FlushE;
  logic        StallMD, DoneE;
  logic [31:0] ResultE;

  int total = 0;
  int bad   = 0;

  muldiv_unit_e #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MulDivE(MulDivE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .StallMD(StallMD), .DoneE(DoneE), .ResultE(ResultE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    p  = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3 == 3'd4 || f3 == 3'd6)
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op at a negedge (cycle T) and hold it until DoneE; lat = cycles from T to DoneE
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls,
                        output logic stall_at_done);
    funct3E = f3; SrcAE = a; SrcBE = b; MulDivE = 1'b1;
    lat = 0; stalls = 0; res = 32'd0; stall_at_done = 1'b1;
    #1;
    if (StallMD) stalls++;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (DoneE) begin
        res = ResultE;
        stall_at_done = StallMD;
        break;
      end
      if (StallMD) stalls++;
    end
    MulDivE = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[15];

  initial begin
    logic [31:0] res;
    int lat, stalls, n_done, n_stall;
    logic sd;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    tv[0]  = '{"mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tv[1]  = '{"mulhu_ff",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tv[2]  = '{"mulh_ff",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    tv[3]  = '{"mulhsu_ff",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tv[4]  = '{"div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tv[5]  = '{"rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tv[6]  = '{"divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14};
    tv[7]  = '{"remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2};
    tv[8]  = '{"div_5_0",      3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    tv[9]  = '{"remu_5_0",     3'd7, 32'd5,          32'd0,         32'd5};
    tv[10] = '{"div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tv[11] = '{"rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    tv[12] = '{"mul_min_min",  3'd0, 32'h8000_0000,  32'h8000_0000, 32'd0};
    tv[13] = '{"divu_max_1",   3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};
    tv[14] = '{"rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1};

    rst = 1'b1; MulDivE = 1'b1; funct3E = 3'd0; SrcAE = 32'd3; SrcBE = 32'd4; FlushE = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, StallMD}, 32'd0);
    chk("rst_done",  {31'd0, DoneE},   32'd0);
    chk("rst_result", ResultE,          32'd0);
    MulDivE = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    foreach (tv[i]) begin
      run_op(tv[i].f3, tv[i].a, tv[i].b, res, lat, stalls, sd);
      chk({tv[i].name, "_res"},   res, tv[i].exp);
      chk({tv[i].name, "_lat"},   32'(lat), 32'(ref_lat(tv[i].f3, tv[i].a, tv[i].b)));
      chk({tv[i].name, "_stall"}, 32'(stalls), 32'(lat));
      chk({tv[i].name, "_sdone"}, {31'd0, sd}, 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rf3, ra, rb, res, lat, stalls, sd);
      chk("rand_res", res, ref_model(rf3, ra, rb));
      chk("rand_lat", 32'(lat), 32'(ref_lat(rf3, ra, rb)));
      @(negedge clk);
    end

    // Result must hold after DONE with DoneE low
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, stalls, sd);
    @(negedge clk);
    chk("hold_result", ResultE, 32'hFFFF_FFEB);
    chk("hold_done",   {31'd0, DoneE}, 32'd0);

    // Flush at T+10 of a DIVU
    funct3E = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd3; MulDivE = 1'b1;
    repeat (10) @(negedge clk);
    FlushE = 1'b1; MulDivE = 1'b0;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush_stall", {31'd0, StallMD}, 32'd0);
    chk("flush_done",  {31'd0, DoneE},   32'd0);
    n_done = 0; n_stall = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (DoneE) n_done++;
      if (StallMD) n_stall++;
    end
    chk("flush_no_done",  32'(n_done),  32'd0);
    chk("flush_no_stall", 32'(n_stall), 32'd0);
    chk("flush_result",   ResultE, 32'hFFFF_FFEB);

    // Reset at T+5 of a DIV
    funct3E = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd7; MulDivE = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_stall_forced", {31'd0, StallMD}, 32'd0);
    @(negedge clk);
    rst = 1'b0; MulDivE = 1'b0;
    chk("rstmid_done",   {31'd0, DoneE},   32'd0);
    chk("rstmid_result", ResultE,          32'd0);
    chk("rstmid_stall",  {31'd0, StallMD}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (DoneE) n_done++;
    end
    chk("rstmid_no_done", 32'(n_done), 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, stalls, sd);
    chk("post_rst_mul_res", res, 32'hFFFF_FFEB);
    chk("post_rst_mul_lat", 32'(lat), 32'(ref_lat(3'd0, 32'd7, 32'hFFFF_FFFD)));
    chk("post_rst_mul_stall", 32'(stalls), 32'(lat));
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
